pc_next_unit: RTL and testbench

- Parametrised program-counter register and next-PC selector for the pipelined CPU.
- Holds the architectural PC and computes PC+INSTR_BYTES.
- Selects among sequential, branch, jump (upper PC bits concatenated with a pre-shifted target field) and jump-register targets.
- Supports stall, deferred redirect while stalled, and a start-gated run state.

---
 rtl/pc_next_unit.sv | 130 +++++++++++++
 tb/tb_pc_next_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_next_unit.sv
// rtl/pc_next_unit.sv - program counter register and next-PC selector (optional PC_PERF_CNT_EN redirect counter)
module pc_next_unit #(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       JUMP_W      = 28,
  parameter int unsigned       INSTR_BYTES = 4,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              stall_i,
  input  logic              branch_i,
  input  logic [ADDR_W-1:0] branch_addr_i,
  input  logic              jump_i,
  input  logic [JUMP_W-1:0] jump_addr_i,
  input  logic              jr_i,
  input  logic [ADDR_W-1:0] jr_addr_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] pc_plus_o,
  output logic              valid_o,
  output logic              pending_o
`ifdef PC_PERF_CNT_EN
  ,output logic [31:0]      redirect_cnt_o
`endif
);

  typedef enum logic {ST_IDLE, ST_RUN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
  logic              pending_q, pending_d;
  logic [ADDR_W-1:0] pc_plus;
  logic [ADDR_W-1:0] jump_tgt;
  logic [ADDR_W-1:0] redir_tgt;
  logic              redir_req;

  // Sequential successor wraps naturally at 2^ADDR_W.
  assign pc_plus  = pc_q + ADDR_W'(INSTR_BYTES);
  // Jump keeps the upper region bits of the next PC and replaces the rest.
  assign jump_tgt = {pc_plus[ADDR_W-1:JUMP_W], jump_addr_i};
  assign redir_req = branch_i | jump_i | jr_i;

  // Resolve the winning redirect target: branch over jump over jump-register.
  always_comb begin
    redir_tgt = jr_addr_i;
    if (branch_i) begin
      redir_tgt = branch_addr_i;
    end else if (jump_i) begin
      redir_tgt = jump_tgt;
    end
  end

  // Next-state, next-PC and deferred-redirect bookkeeping.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pending_d  = pending_q;
    pend_tgt_d = pend_tgt_q;
    case (state_q)
      ST_IDLE: begin
        pc_d = RESET_PC;
        if (start_i) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stall_i) begin
          // PC holds; a redirect seen now is remembered for stall release.
          if (redir_req) begin
            pending_d  = 1'b1;
            pend_tgt_d = redir_tgt;
          end
        end else if (redir_req) begin
          pc_d      = redir_tgt;
          pending_d = 1'b0;
        end else if (pending_q) begin
          pc_d      = pend_tgt_q;
          pending_d = 1'b0;
        end else begin
          pc_d = pc_plus;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, PC and pending redirect registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      pending_q  <= 1'b0;
      pend_tgt_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pending_q  <= pending_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  assign pc_o      = pc_q;
  assign pc_plus_o = pc_plus;
  assign valid_o   = (state_q == ST_RUN);
  assign pending_o = pending_q;

`ifdef PC_PERF_CNT_EN
  logic [31:0] cnt_q, cnt_d;
  logic        cnt_inc;

  // A count is taken whenever the PC is actually loaded from a non-sequential target.
  assign cnt_inc = (state_q == ST_RUN) && !stall_i && (redir_req || pending_q);
  assign cnt_d   = cnt_inc ? cnt_q + 32'd1 : cnt_q;

  // Redirect counter register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign redirect_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_pc_next_unit.sv
// tb/tb_pc_next_unit.sv - randomized self-checking bench for pc_next_unit against a behavioural model
module tb_pc_next_unit;

  localparam int ADDR_W = 32;
  localparam int JUMP_W = 28;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              start_i, stall_i, branch_i, jump_i, jr_i;
  logic [ADDR_W-1:0] branch_addr_i, jr_addr_i;
  logic [JUMP_W-1:0] jump_addr_i;
  logic [ADDR_W-1:0] pc_o, pc_plus_o;
  logic              valid_o, pending_o;
`ifdef PC_PERF_CNT_EN
  logic [31:0]       redirect_cnt_o;
`endif

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  bit          m_run, m_pend;
  logic [31:0] m_pc, m_tgt, m_cnt;

  always #5 clk_i = ~clk_i;

  pc_next_unit #(
    .ADDR_W(ADDR_W), .JUMP_W(JUMP_W), .INSTR_BYTES(4), .RESET_PC('0)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stall_i(stall_i),
    .branch_i(branch_i), .branch_addr_i(branch_addr_i),
    .jump_i(jump_i), .jump_addr_i(jump_addr_i),
    .jr_i(jr_i), .jr_addr_i(jr_addr_i),
    .pc_o(pc_o), .pc_plus_o(pc_plus_o), .valid_o(valid_o), .pending_o(pending_o)
`ifdef PC_PERF_CNT_EN
    ,.redirect_cnt_o(redirect_cnt_o)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_run  = 0;
    m_pend = 0;
    m_pc   = 32'h0;
    m_tgt  = 32'h0;
    m_cnt  = 32'h0;
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".pc"},      pc_o,             m_pc);
    check_eq({tag, ".pc_plus"}, pc_plus_o,        m_pc + 32'd4);
    check_eq({tag, ".valid"},   {31'd0, valid_o}, {31'd0, m_run});
    check_eq({tag, ".pending"}, {31'd0, pending_o}, {31'd0, m_pend});
`ifdef PC_PERF_CNT_EN
    check_eq({tag, ".cnt"},     redirect_cnt_o,   m_cnt);
`endif
  endtask

  // One clock edge: model consumes the inputs present at the edge, then outputs are compared.
  task automatic tick(input string tag);
    bit          have;
    logic [31:0] t;
    have = branch_i || jump_i || jr_i;
    if (branch_i)    t = branch_addr_i;
    else if (jump_i) t = ((m_pc + 32'd4) & ~((32'h1 << JUMP_W) - 32'h1)) | 32'(jump_addr_i);
    else             t = jr_addr_i;
    @(posedge clk_i);
    #1;
    if (!m_run) begin
      if (start_i) m_run = 1;
    end else if (stall_i) begin
      if (have) begin m_pend = 1; m_tgt = t; end
    end else if (have) begin
      m_pc = t; m_pend = 0; m_cnt++;
    end else if (m_pend) begin
      m_pc = m_tgt; m_pend = 0; m_cnt++;
    end else begin
      m_pc = m_pc + 32'd4;
    end
    check_all(tag);
  endtask

  task automatic drive(input bit st, input bit s, input bit b, input logic [31:0] ba,
                       input bit j, input logic [31:0] ja, input bit r, input logic [31:0] ra);
    start_i = st; stall_i = s;
    branch_i = b; branch_addr_i = ba;
    jump_i = j;   jump_addr_i = ja[JUMP_W-1:0];
    jr_i = r;     jr_addr_i = ra;
  endtask

  task automatic idle_inputs();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Asynchronous reset pulse between clock edges, then restart fetching.
  task automatic reset_and_start(input string tag);
    rst_i = 1'b0;
    #2;
    model_reset();
    check_all({tag, ".async"});
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    idle_inputs();
    start_i = 1'b1;
    tick({tag, ".start"});
    idle_inputs();
  endtask

  task automatic jr_to(input logic [31:0] a, input string tag);
    drive(0, 0, 0, 0, 0, 0, 1, a);
    tick(tag);
  endtask

  initial begin
    idle_inputs();
    model_reset();
    rst_i = 1'b0;
    #3;
    check_all("reset");
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;

    // IDLE ignores redirects and stalls.
    drive(0, 1, 1, 32'h1234, 1, 32'h40, 1, 32'h88);
    tick("idle_ignore");
    check_eq("idle_valid_low", {31'd0, valid_o}, 32'd0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    tick("start");
    check_eq("first_run_pc", pc_o, 32'h0);
    check_eq("first_run_valid", {31'd0, valid_o}, 32'd1);
    idle_inputs();
    tick("seq1"); check_eq("seq_0x4", pc_o, 32'h4);
    tick("seq2"); check_eq("seq_0x8", pc_o, 32'h8);
    tick("seq3"); check_eq("seq_0xC", pc_o, 32'hC);

    // Jump concatenation
    jr_to(32'h4000_0010, "jr_setup1");
    drive(0, 0, 0, 0, 1, 32'h000_0100, 0, 0);
    tick("jump1"); check_eq("jump_concat", pc_o, 32'h4000_0100);
    jr_to(32'hF000_0000, "jr_setup2");
    drive(0, 0, 0, 0, 1, 32'hFFF_FFFC, 0, 0);
    tick("jump2"); check_eq("jump_top", pc_o, 32'hFFFF_FFFC);
    idle_inputs();
    tick("wrap"); check_eq("seq_wrap", pc_o, 32'h0);

    // Priority
    drive(0, 0, 1, 32'h200, 1, 32'h300, 1, 32'h400);
    tick("prio"); check_eq("prio_branch", pc_o, 32'h200);

    // Stall with deferred branch
    jr_to(32'h20, "stall_setup");
    drive(0, 1, 1, 32'h80, 0, 0, 0, 0);
    tick("stall1");
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    tick("stall2");
    tick("stall3");
    check_eq("stall_hold_pc", pc_o, 32'h20);
    check_eq("stall_pending", {31'd0, pending_o}, 32'd1);
    idle_inputs();
    tick("release"); check_eq("release_pc", pc_o, 32'h80);
    check_eq("release_pending", {31'd0, pending_o}, 32'd0);

    // New redirect on release wins over pending one
    jr_to(32'h20, "stall_setup2");
    drive(0, 1, 1, 32'h80, 0, 0, 0, 0);
    tick("stall_b");
    drive(0, 0, 0, 0, 0, 0, 1, 32'h100);
    tick("release_jr"); check_eq("release_new_wins", pc_o, 32'h100);

    // Async reset mid-stall with pending redirect
    jr_to(32'h20, "stall_setup3");
    drive(0, 1, 1, 32'h80, 0, 0, 0, 0);
    tick("stall_c");
    reset_and_start("rst_mid");
    check_eq("restart_pc", pc_o, 32'h0);
    tick("restart_seq"); check_eq("no_stale_redirect", pc_o, 32'h4);

`ifdef PC_PERF_CNT_EN
    // Counter: 2 direct branches, 1 pending-applied jump, 5 sequential edges
    reset_and_start("cnt");
    drive(0, 0, 1, 32'h100, 0, 0, 0, 0); tick("cnt_b1");
    drive(0, 0, 1, 32'h200, 0, 0, 0, 0); tick("cnt_b2");
    drive(0, 1, 0, 0, 1, 32'h40, 0, 0);  tick("cnt_stall");
    idle_inputs();                        tick("cnt_apply");
    for (int i = 0; i < 5; i++) tick("cnt_seq");
    check_eq("cnt_total", redirect_cnt_o, 32'd3);
`endif

    // Randomized run with occasional async resets
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] ra, rb;
      if ($urandom_range(0, 399) == 0) begin
        reset_and_start("rnd_rst");
      end else begin
        ra = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
        rb = $urandom;
        drive($urandom_range(0, 1) == 1,
              $urandom_range(0, 2) == 0,
              $urandom_range(0, 5) == 0, rb,
              $urandom_range(0, 5) == 0, $urandom,
              $urandom_range(0, 5) == 0, ra);
        tick("rnd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
